// File: rtl/bus_serializer.sv
// bus_serializer
// Parallel-to-serial transmitter. Accepts WIDTH-bit words on a valid/ready
// handshake and sends each word one bit per cycle, LSB first, on a serial
// valid/ready handshake with a last-bit marker. Back-to-back words stream
// with no idle cycle. frames_sent counts completed words and wraps silently.
//
// Handshake semantics (both sides): a transfer happens at a rising clk edge
// where valid and ready are both high. The parallel side transfers a word
// (in_valid & in_ready); the serial side transfers one bit
// (ser_valid & ser_ready). A valid source holds its payload until the
// transfer. in_ready never depends on in_valid.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   data_in      parallel word, bit 0 sent first
//   in_valid     data_in holds a word to send
//   in_ready     word accepted this cycle when in_valid is also high
//   ser_out      current serial bit (registered)
//   ser_valid    ser_out carries a valid bit (registered)
//   ser_last     ser_out is bit WIDTH-1 of its word (registered)
//   ser_ready    downstream takes ser_out this cycle
//   frames_sent  completed-word counter, modulo 2^CNT_W
//   dbg_state    current FSM state (0 = IDLE, 1 = SHIFT)

module bus_serializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic [CNT_W-1:0] frames_sent,
    output logic             dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;

    logic at_last;
    logic taken;
    logic accept;

    always_comb begin
        at_last = (bit_cnt_q == LAST_IDX);
        // In SHIFT ser_valid is always high, so a bit is taken on ser_ready.
        taken   = (state_q == SHIFT) && ser_ready;
        // A new word may enter only when the shift register is free now or
        // is being emptied at this edge by the last bit being taken.
        in_ready = rst_n && ((state_q == IDLE) || (at_last && taken));
        accept   = in_valid && in_ready;

        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        frames_d  = frames_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d      = data_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (taken) begin
                    if (!at_last) begin
                        sh_d      = {1'b0, sh_q[WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else begin
                        frames_d = frames_q + CNT_W'(1);
                        if (accept) begin
                            sh_d      = data_in;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Serial outputs are registered copies of what the next state presents.
        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = ser_valid_d && sh_d[0];
        ser_last_d  = ser_valid_d && (bit_cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            frames_q    <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            frames_q    <= frames_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign ser_last    = ser_last_q;
    assign frames_sent = frames_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bus_serializer.sv
// Testbench for bus_serializer (WIDTH=4, CNT_W=2 so the counter wraps often).
// Inputs change 1 time unit after a rising edge; outputs are compared on the
// falling edge. A queue-based reference model holds the bits still owed to
// the serial link as {last, bit} pairs.

module tb_bus_serializer;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          in_valid;
    logic          in_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_last;
    logic          ser_ready;
    logic [CW-1:0] frames_sent;
    logic          dbg_state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    bus_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .ser_last    (ser_last),
        .ser_ready   (ser_ready),
        .frames_sent (frames_sent),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]    exp_q[$];   // {last, bit} still to be sent
    logic [CW-1:0] m_frames = '0;

    function automatic logic model_ready();
        if (!rst_n) return 1'b0;
        if (exp_q.size() == 0) return 1'b1;
        return exp_q[0][1] && ser_ready;
    endfunction

    always @(posedge clk) begin
        logic ir;
        if (!rst_n) begin
            exp_q.delete();
            m_frames = '0;
        end else begin
            ir = model_ready();
            if (exp_q.size() != 0 && ser_ready) begin
                if (exp_q[0][1]) m_frames = m_frames + 1'b1;
                void'(exp_q.pop_front());
            end
            if (in_valid && ir)
                for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), data_in[i]});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl in_ready", in_ready, model_ready());
            check("mdl ser_valid", ser_valid, exp_q.size() != 0);
            check("mdl frames", frames_sent, m_frames);
            if (exp_q.size() != 0) begin
                check("mdl ser_out", ser_out, exp_q[0][0]);
                check("mdl ser_last", ser_last, exp_q[0][1]);
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst_n;
        logic          iv;
        logic [W-1:0]  d;
        logic          rdy;
        logic          out;
        logic          v;
        logic          l;
        logic          ir;
        logic [CW-1:0] fs;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic iv, input logic [W-1:0] d, input logic rdy,
                       input logic out, input logic v, input logic l, input logic ir,
                       input logic [CW-1:0] fs);
        vec_t t;
        t.rst_n = r; t.iv = iv; t.d = d; t.rdy = rdy;
        t.out = out; t.v = v; t.l = l; t.ir = ir; t.fs = fs;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [W-1:0] d, input logic rdy);
        rst_n = r; in_valid = iv; data_in = d; ser_ready = rdy;
    endtask

    initial begin
        int n;
        drive(1'b0, 1'b0, '0, 1'b1);

        // reset then single word 1011 -> 1,1,0,1
        add(0,0,4'h0,1, 0,0,0,0,0);
        add(1,1,4'hB,1, 0,0,0,1,0);
        add(1,0,4'h0,1, 1,1,0,0,0);
        add(1,0,4'h0,1, 1,1,0,0,0);
        add(1,0,4'h0,1, 0,1,0,0,0);
        add(1,0,4'h0,1, 1,1,1,1,0);
        // back-to-back A,5,F
        add(1,1,4'hA,1, 0,0,0,1,1);
        add(1,1,4'h5,1, 0,1,0,0,1);
        add(1,1,4'h5,1, 1,1,0,0,1);
        add(1,1,4'h5,1, 0,1,0,0,1);
        add(1,1,4'h5,1, 1,1,1,1,1);
        add(1,1,4'hF,1, 1,1,0,0,2);
        add(1,1,4'hF,1, 0,1,0,0,2);
        add(1,1,4'hF,1, 1,1,0,0,2);
        add(1,1,4'hF,1, 0,1,1,1,2);
        add(1,0,4'h0,1, 1,1,0,0,3);
        add(1,0,4'h0,1, 1,1,0,0,3);
        add(1,0,4'h0,1, 1,1,0,0,3);
        add(1,0,4'h0,1, 1,1,1,1,3);
        // backpressure on bit 1 of 6 -> 0,1,1,0 ; counter has wrapped to 0
        add(1,1,4'h6,1, 0,0,0,1,0);
        add(1,0,4'h0,1, 0,1,0,0,0);
        add(1,0,4'h0,0, 1,1,0,0,0);
        add(1,0,4'h0,0, 1,1,0,0,0);
        add(1,0,4'h0,0, 1,1,0,0,0);
        add(1,0,4'h0,1, 1,1,0,0,0);
        add(1,0,4'h0,1, 1,1,0,0,0);
        add(1,0,4'h0,1, 0,1,1,1,0);
        // stall on last bit of 9 with word 3 pending
        add(1,1,4'h9,1, 0,0,0,1,1);
        add(1,0,4'h0,1, 1,1,0,0,1);
        add(1,0,4'h0,1, 0,1,0,0,1);
        add(1,0,4'h0,1, 0,1,0,0,1);
        add(1,1,4'h3,0, 1,1,1,0,1);
        add(1,1,4'h3,0, 1,1,1,0,1);
        add(1,1,4'h3,1, 1,1,1,1,1);
        add(1,0,4'h0,1, 1,1,0,0,2);
        add(1,0,4'h0,1, 1,1,0,0,2);
        add(1,0,4'h0,1, 0,1,0,0,2);
        add(1,0,4'h0,1, 0,1,1,1,2);
        // reset after bit 1 of C, then word 3 -> 1,1,0,0
        add(1,1,4'hC,1, 0,0,0,1,3);
        add(1,0,4'h0,1, 0,1,0,0,3);
        add(1,0,4'h0,1, 0,1,0,0,3);
        add(0,0,4'h0,1, 1,1,0,0,3);
        add(0,0,4'h0,1, 0,0,0,0,0);
        add(1,1,4'h3,1, 0,0,0,1,0);
        add(1,0,4'h0,1, 1,1,0,0,0);
        add(1,0,4'h0,1, 1,1,0,0,0);
        add(1,0,4'h0,1, 0,1,0,0,0);
        add(1,0,4'h0,1, 0,1,1,1,0);
        add(1,0,4'h0,1, 0,0,0,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].rst_n, tbl[i].iv, tbl[i].d, tbl[i].rdy);
            chk_en = 1'b1;
            @(negedge clk);
            check($sformatf("row%0d in_ready", i), in_ready, tbl[i].ir);
            check($sformatf("row%0d ser_valid", i), ser_valid, tbl[i].v);
            check($sformatf("row%0d ser_last", i), ser_last, tbl[i].l);
            check($sformatf("row%0d frames", i), frames_sent, tbl[i].fs);
            if (tbl[i].v) check($sformatf("row%0d ser_out", i), ser_out, tbl[i].out);
        end

        // ---------------- randomized stimulus ----------------
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
                  W'($urandom), ($urandom_range(0, 9) < 7));
        end

        // ---------------- drain with bounded wait ----------------
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, '0, 1'b1);
        n = 0;
        while (ser_valid && n < 2 * W + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        check("drain ser_valid", ser_valid, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
